// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the byte-write true dual-port RAM.
package tdp_ram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST,
        RDW_WRITE_FIRST,
        RDW_NO_CHANGE
    } rdw_mode_e;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    function automatic int unsigned calc_nb(input int unsigned data_w, input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/tdp_ram_port.sv
// Per-port read path: read-during-write selection, optional output register, rvalid.
module tdp_ram_port
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned BYTEWIDTH = 8,
    parameter int unsigned NB        = 2,
    parameter rdw_mode_e   RDW_MODE  = RDW_READ_FIRST,
    parameter int unsigned OUT_REG   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NB-1:0]        we,
    input  logic [DATAWIDTH-1:0] din,
    input  logic [DATAWIDTH-1:0] rdata,
    output logic [DATAWIDTH-1:0] dout,
    output logic                 rvalid
);

    logic [DATAWIDTH-1:0] merged;
    logic [DATAWIDTH-1:0] dout1_q, dout1_d;
    logic                 rvalid1_q, rvalid1_d;

    // Own-port view of the word after this port's lanes land; the other port is ignored.
    always_comb begin
        merged = rdata;
        for (int b = 0; b < int'(NB); b++) begin
            if (we[b]) begin
                merged[b*BYTEWIDTH +: BYTEWIDTH] = din[b*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    always_comb begin
        dout1_d   = dout1_q;
        rvalid1_d = 1'b0;
        if (en) begin
            if (!(RDW_MODE == RDW_NO_CHANGE && |we)) begin
                rvalid1_d = 1'b1;
                dout1_d   = (RDW_MODE == RDW_WRITE_FIRST) ? merged : rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout1_q   <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            dout1_q   <= dout1_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATAWIDTH-1:0] dout2_q, dout2_d;
            logic                 rvalid2_q, rvalid2_d;

            always_comb begin
                dout2_d   = rvalid1_q ? dout1_q : dout2_q;
                rvalid2_d = rvalid1_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout2_q   <= '0;
                    rvalid2_q <= 1'b0;
                end else begin
                    dout2_q   <= dout2_d;
                    rvalid2_q <= rvalid2_d;
                end
            end

            assign dout   = dout2_q;
            assign rvalid = rvalid2_q;
        end else begin : g_no_out_reg
            assign dout   = dout1_q;
            assign rvalid = rvalid1_q;
        end
    endgenerate

endmodule

// File: rtl/tdp_bytewrite_ram.sv
// True dual-port RAM with byte enables, zero-fill sweep after reset and
// deterministic same-address collision handling (port A wins shared lanes).
module tdp_bytewrite_ram
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATAWIDTH      = 16,
    parameter int unsigned ADDRWIDTH      = 8,
    parameter int unsigned BYTEWIDTH      = 8,
    parameter rdw_mode_e   RDW_MODE       = RDW_READ_FIRST,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    output logic                                    init_done,
    input  logic                                    ena,
    input  logic [calc_nb(DATAWIDTH, BYTEWIDTH)-1:0] wea,
    input  logic [ADDRWIDTH-1:0]                    addra,
    input  logic [DATAWIDTH-1:0]                    dina,
    output logic [DATAWIDTH-1:0]                    douta,
    output logic                                    rvalida,
    input  logic                                    enb,
    input  logic [calc_nb(DATAWIDTH, BYTEWIDTH)-1:0] web,
    input  logic [ADDRWIDTH-1:0]                    addrb,
    input  logic [DATAWIDTH-1:0]                    dinb,
    output logic [DATAWIDTH-1:0]                    doutb,
    output logic                                    rvalidb,
    output logic                                    collision
);

    localparam int unsigned NB    = calc_nb(DATAWIDTH, BYTEWIDTH);
    localparam int unsigned DEPTH = 2 ** ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] sweep_q, sweep_d;
    logic                 ready, acc_a, acc_b, coll_now;
    logic [NB-1:0]        wen_a, wen_b;
    logic [DATAWIDTH-1:0] rdata_a, rdata_b;

    assign ready     = (state_q == ST_READY);
    assign init_done = ready;
    assign acc_a     = ena & ready;
    assign acc_b     = enb & ready;
    assign wen_a     = wea & {NB{acc_a}};
    assign wen_b     = web & {NB{acc_b}};
    assign coll_now  = acc_a & acc_b & (addra == addrb) & ((|wen_a) | (|wen_b));
    assign rdata_a   = mem_q[addra];
    assign rdata_b   = mem_q[addrb];

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            if (CLEAR_ON_RESET == 0 || (&sweep_q)) begin
                state_d = ST_READY;
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Single write process; A's lane assignment comes last so it wins on a shared lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_q[sweep_q] <= '0;
                end
            end else begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (wen_b[b]) begin
                        mem_q[addrb][b*BYTEWIDTH +: BYTEWIDTH] <= dinb[b*BYTEWIDTH +: BYTEWIDTH];
                    end
                    if (wen_a[b]) begin
                        mem_q[addra][b*BYTEWIDTH +: BYTEWIDTH] <= dina[b*BYTEWIDTH +: BYTEWIDTH];
                    end
                end
            end
        end
    end

    logic coll1_q, coll1_d;

    assign coll1_d = coll_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            coll1_q <= 1'b0;
        end else begin
            coll1_q <= coll1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_coll_reg
            logic coll2_q, coll2_d;

            assign coll2_d = coll1_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    coll2_q <= 1'b0;
                end else begin
                    coll2_q <= coll2_d;
                end
            end

            assign collision = coll2_q;
        end else begin : g_coll_direct
            assign collision = coll1_q;
        end
    endgenerate

    tdp_ram_port #(
        .DATAWIDTH (DATAWIDTH),
        .BYTEWIDTH (BYTEWIDTH),
        .NB        (NB),
        .RDW_MODE  (RDW_MODE),
        .OUT_REG   (OUT_REG)
    ) u_port_a (
        .clk    (clk),
        .rst    (rst),
        .en     (acc_a),
        .we     (wen_a),
        .din    (dina),
        .rdata  (rdata_a),
        .dout   (douta),
        .rvalid (rvalida)
    );

    tdp_ram_port #(
        .DATAWIDTH (DATAWIDTH),
        .BYTEWIDTH (BYTEWIDTH),
        .NB        (NB),
        .RDW_MODE  (RDW_MODE),
        .OUT_REG   (OUT_REG)
    ) u_port_b (
        .clk    (clk),
        .rst    (rst),
        .en     (acc_b),
        .we     (wen_b),
        .din    (dinb),
        .rdata  (rdata_b),
        .dout   (doutb),
        .rvalid (rvalidb)
    );

endmodule

// File: tb/tb_tdp_bytewrite_ram.sv
// Scoreboard bench: four RAM variants share one stimulus stream; a monitor pops expectations.
module tb_tdp_bytewrite_ram;
    import tdp_ram_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NP = 8;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena, enb;
    logic [1:0]    wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb;

    logic [DW-1:0] dout_w  [NP];
    logic          rv_w    [NP];
    logic          idone_w [ND];
    logic          coll_w  [ND];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        bit          chk;
    } exp_t;

    exp_t        sb_q [NP][$];
    bit          coll_iss [4096];
    logic [15:0] mdl [16];
    bit          model_ready;
    int          n_cmp = 0;
    int          n_bad = 0;

    // u0: read-first, u1: write-first, u2: no-change, u3: read-first with output register
    tdp_bytewrite_ram #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDW_MODE(RDW_READ_FIRST),
                        .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .init_done(idone_w[0]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_w[0]), .rvalida(rv_w[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_w[1]), .rvalidb(rv_w[1]),
        .collision(coll_w[0]));

    tdp_bytewrite_ram #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDW_MODE(RDW_WRITE_FIRST),
                        .OUT_REG(0), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .init_done(idone_w[1]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_w[2]), .rvalida(rv_w[2]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_w[3]), .rvalidb(rv_w[3]),
        .collision(coll_w[1]));

    tdp_bytewrite_ram #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDW_MODE(RDW_NO_CHANGE),
                        .OUT_REG(0), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .rst(rst), .init_done(idone_w[2]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_w[4]), .rvalida(rv_w[4]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_w[5]), .rvalidb(rv_w[5]),
        .collision(coll_w[2]));

    tdp_bytewrite_ram #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RDW_MODE(RDW_READ_FIRST),
                        .OUT_REG(1), .CLEAR_ON_RESET(1)) u3 (
        .clk(clk), .rst(rst), .init_done(idone_w[3]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_w[6]), .rvalida(rv_w[6]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_w[7]), .rvalidb(rv_w[7]),
        .collision(coll_w[3]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int p, input int k, input logic [1:0] w,
                                 input logic [15:0] old_w, input logic [15:0] own_w, input bit coll);
        exp_t e;
        if (k == 2 && w != 2'b00) return;
        e.cyc  = cyc + ((k == 3) ? 2 : 1);
        e.data = (k == 1) ? own_w : old_w;
        // Own-port merge under a same-address collision is not pinned down for write-first.
        e.chk  = !(k == 1 && coll);
        sb_q[p].push_back(e);
    endfunction

    task automatic acc(input bit ea, input logic [1:0] wa, input logic [3:0] aa,
                       input logic [15:0] da, input bit eb, input logic [1:0] wb,
                       input logic [3:0] ab, input logic [15:0] db);
        logic [15:0] old_a, old_b, own_a, own_b;
        bit          coll;
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        if (model_ready) begin
            old_a = mdl[aa];
            old_b = mdl[ab];
            own_a = old_a;
            own_b = old_b;
            for (int b = 0; b < 2; b++) begin
                if (wa[b]) own_a[b*8 +: 8] = da[b*8 +: 8];
                if (wb[b]) own_b[b*8 +: 8] = db[b*8 +: 8];
            end
            coll = ea && eb && (aa == ab) && (wa != 2'b00 || wb != 2'b00);
            coll_iss[cyc] = coll;
            for (int k = 0; k < ND; k++) begin
                if (ea) push(2*k, k, wa, old_a, own_a, coll);
                if (eb) push(2*k + 1, k, wb, old_b, own_b, coll);
            end
            if (eb) mdl[ab] = own_b;
            if (ea) begin
                for (int b = 0; b < 2; b++) begin
                    if (wa[b]) mdl[aa][b*8 +: 8] = da[b*8 +: 8];
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        ena = 1'b0; enb = 1'b0; wea = 2'b00; web = 2'b00;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset_outputs();
        for (int k = 0; k < ND; k++) begin
            chk("reset_outputs", {idone_w[k], coll_w[k], rv_w[2*k], rv_w[2*k+1],
                                  dout_w[2*k], dout_w[2*k+1]}, 64'd0);
        end
    endtask

    // Releases reset; init_done must stay low for 16 edges and rise on the 16th.
    task automatic wait_init(input bit poke);
        rst = 1'b0;
        if (poke) begin
            ena = 1'b1; enb = 1'b1; wea = 2'b11; web = 2'b11;
            addra = 4'd2; addrb = 4'd2; dina = 16'hFFFF; dinb = 16'hEEEE;
        end
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) chk("init_done", 64'(idone_w[d]), 64'(k == 16));
            if (k < 16) @(posedge clk);
        end
        ena = 1'b0; enb = 1'b0; wea = 2'b00; web = 2'b00;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        model_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (rv_w[p] === 1'b1) begin
                    n_cmp++;
                    if (sb_q[p].size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_rvalid port %0d: got rvalid=1 at cycle %0d, required none",
                                 p, cyc);
                    end else begin
                        e = sb_q[p].pop_front();
                        if (e.cyc != cyc || (e.chk && dout_w[p] !== e.data)) begin
                            n_bad++;
                            $display("FAIL read port %0d: got %h at cycle %0d, required %h at cycle %0d",
                                     p, dout_w[p], cyc, e.data, e.cyc);
                        end
                    end
                end
            end
            if (cyc >= 3) begin
                for (int k = 0; k < ND; k++) begin
                    lat = (k == 3) ? 2 : 1;
                    chk("collision", 64'(coll_w[k]), 64'(coll_iss[cyc - lat]));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish, required finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        ena = 1'b0; enb = 1'b0; wea = 2'b00; web = 2'b00;
        addra = '0; addrb = '0; dina = '0; dinb = '0;
        model_ready = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        wait_init(1'b0);

        // Array cleared: every address reads zero on both ports.
        for (int i = 0; i < 16; i++) acc(1'b1, 2'b00, 4'(i), 16'h0, 1'b1, 2'b00, 4'(15 - i), 16'h0);
        idle(3);

        // Full-word write, cross-port readback, then upper-byte-only write.
        acc(1'b1, 2'b11, 4'd3, 16'hBEEF, 1'b0, 2'b00, 4'd0, 16'h0);
        acc(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 2'b00, 4'd3, 16'h0);
        acc(1'b1, 2'b10, 4'd3, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0);
        acc(1'b1, 2'b00, 4'd3, 16'h0, 1'b1, 2'b00, 4'd3, 16'h0);

        // Own-port read-during-write at addr 7.
        acc(1'b1, 2'b11, 4'd7, 16'hAAAA, 1'b0, 2'b00, 4'd0, 16'h0);
        acc(1'b1, 2'b00, 4'd7, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0);
        acc(1'b1, 2'b11, 4'd7, 16'h5555, 1'b0, 2'b00, 4'd0, 16'h0);
        chk("no_change_hold_dout", 64'(dout_w[4]), 64'h0000_0000_0000_AAAA);
        chk("no_change_rvalid", 64'(rv_w[4]), 64'd0);
        acc(1'b1, 2'b00, 4'd7, 16'h0, 1'b1, 2'b00, 4'd7, 16'h0);
        acc(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 2'b01, 4'd9, 16'h77CD);
        acc(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 2'b00, 4'd9, 16'h0);

        // Same-address collisions.
        acc(1'b1, 2'b01, 4'd5, 16'h1111, 1'b1, 2'b11, 4'd5, 16'h2222);
        acc(1'b1, 2'b00, 4'd5, 16'h0, 1'b1, 2'b00, 4'd5, 16'h0);
        acc(1'b1, 2'b11, 4'd5, 16'h3333, 1'b1, 2'b00, 4'd5, 16'h0);
        acc(1'b1, 2'b00, 4'd5, 16'h0, 1'b1, 2'b00, 4'd5, 16'h0);
        acc(1'b1, 2'b11, 4'd2, 16'h0202, 1'b1, 2'b11, 4'd12, 16'h0C0C);
        acc(1'b1, 2'b00, 4'd12, 16'h0, 1'b1, 2'b00, 4'd2, 16'h0);
        idle(4);

        // Reset with live data on the outputs, then abort the sweep at address 9.
        model_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        wait_init(1'b1);

        // Streaming reads on both ports after the restarted sweep.
        for (int i = 0; i < 16; i++) acc(1'b1, 2'b00, 4'(i), 16'h0, 1'b1, 2'b00, 4'(i), 16'h0);
        idle(4);

        for (int p = 0; p < NP; p++) chk("scoreboard_drained", 64'(sb_q[p].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdp_bytewrite_ram.md
# tdp_bytewrite_ram

Second-generation true dual-port RAM for the project_4 memory subsystem. It adds per-byte write enables, port enables, a selectable read-during-write mode and an optional output pipeline stage with read-valid flags. It also adds deterministic same-address collision resolution and a reset-triggered sweep that clears the array. Other blocks use it as a shared buffer between two independent masters in one clock domain.

## Interface
- DATAWIDTH, 16, word width; must be a multiple of BYTEWIDTH
- ADDRWIDTH, 8, address width; depth = 2**ADDRWIDTH
- BYTEWIDTH, 8, bits per write-enable lane; NB = DATAWIDTH/BYTEWIDTH
- RDW_MODE, RDW_READ_FIRST, own-port read-during-write behaviour (rdw_mode_e)
- OUT_REG, 0, 1 adds one output register stage per port
- CLEAR_ON_RESET, 1, 1 runs zero-fill sweep after reset; 0 skips straight to READY
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- init_done  output  1  high when ports are accepted
- ena / enb  input  1  port enable; no access when low
- wea / web  input  NB  byte write enables, qualified by port enable
- addra / addrb  input  ADDRWIDTH  word address
- dina / dinb  input  DATAWIDTH  write data
- douta / doutb  output  DATAWIDTH  read data
- rvalida / rvalidb  output  1  douta/doutb valid this cycle
- collision  output  1  pulse: same-address conflict was resolved

## Operation
- FSM states INIT and READY. rst=1 forces INIT with sweep address 0; if CLEAR_ON_RESET=0, the first cycle after reset enters READY.
- INIT writes all-zero words to address 0..depth-1, one per cycle. Port enables are ignored and rvalid stays 0. The cycle after the write to depth-1, the FSM enters READY and init_done=1.
- rst asserted mid-sweep restarts the sweep at address 0. Array contents are otherwise unaffected by reset.
- READY, port enable=1: bytes with the enable bit set are written; a read is always performed.
- Read data for a port's own write follows RDW_MODE:
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: returns the merged post-write word.
  - NO_CHANGE: dout holds its value and rvalid=0 for any cycle with a nonzero write enable.
- Cross-port access (A writes, B reads the same address): the reader gets the pre-write word, in every mode.
- Collision means both ports enabled, same address, and at least one nonzero write enable. For byte lanes both ports write, A wins; lanes written by only one port take that port's data.
- collision is a one-cycle pulse aligned with the rvalid of the colliding accesses.
- Reset values: douta=doutb=0, rvalida=rvalidb=0, collision=0, init_done=0.

## Timing
- Read latency is 1+OUT_REG cycles from the enable-sampled edge to rvalid/dout. Back-to-back reads give one result per cycle.
- Writes are visible to any read sampled on the next edge or later.
- rvalid is the enable pipelined by the same latency (zeroed on NO_CHANGE write cycles). dout holds its last value when rvalid=0.
- Sweep duration is 2**ADDRWIDTH cycles after rst deasserts; init_done rises on the next edge.
- No handshake or back-pressure: every enabled access in READY completes.

## Structure
- Package tdp_ram_pkg holds:
  - rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_NO_CHANGE}
  - state_e {ST_INIT, ST_READY}
  - localparam function computing NB
- Top holds the single array, the FSM, sweep counter, collision detection and byte-merge write logic. Writes happen in one always_ff so that collision priority is deterministic.
- Sub-module tdp_ram_port is instantiated twice. It holds RDW selection, the optional OUT_REG stage, and rvalid generation.

## Test plan
- Reset, DATAWIDTH=16, ADDRWIDTH=4 -> init_done low 16 cycles then high; read every address -> 0x0000, rvalid at latency 1+OUT_REG.
- A writes 0xBEEF to addr 3 with wea=2'b11; next cycle B reads addr 3 -> doutb=0xBEEF; then A writes 0x12xx to addr 3 with wea=2'b10 -> readback 0x12EF.
- Own-port write of 0x5555 over 0xAAAA at addr 7:
  - READ_FIRST -> dout=0xAAAA.
  - WRITE_FIRST -> dout=0x5555.
  - NO_CHANGE -> dout unchanged, rvalid=0.
- Both ports write addr 5: A 0x1111 (wea=2'b01), B 0x2222 (web=2'b11) -> word 0x2211, collision=1 for one cycle; A writes while B reads the same address -> B gets the old word, collision=1.
- Assert rst at sweep address 9 after array was written -> sweep restarts at 0, all addresses read 0 after init_done; enables during INIT cause no writes and no rvalid.
- OUT_REG=1 streaming reads of addr 0..15 on both ports -> 16 consecutive rvalid cycles starting 2 cycles after the first enable, data in order.
